// File: rtl/status_pkg.sv
// Shared status encoding for the status code generator and the flag decoder.
package status_pkg;

    typedef logic [1:0] status_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_WARN = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/status_code_gen_if.sv
// Status code handshake: producer drives code + valid, consumer returns ack.
interface status_code_gen_if;
    import status_pkg::*;

    status_t status;
    logic    status_vld;
    logic    status_ack;

    modport master (output status, output status_vld, input status_ack);
    modport slave  (input status, input status_vld, output status_ack);
endinterface

// File: rtl/status_code_gen_hold_timer.sv
// hold_timer: loadable down-counter that keeps WARN alive for HOLD_CYCLES cycles.
// Load wins over clear; the count saturates at zero. active_c reflects the
// next count so the caller sees the level in the same cycle as the load.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    output logic active_c
);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load > clear > decrement-to-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(HOLD_CYCLES);
        end else if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        active_c = (cnt_d != '0);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/status_code_gen.sv
// status_code_gen: priority-encodes busy/warn/error events into a registered
// 2-bit status code and reports every change with a valid/ack handshake.
// Optional macro STATUS_ERR_COUNT_EN adds a saturating error-event counter.
module status_code_gen
    import status_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                evt_busy,
    input  logic                evt_warn,
    input  logic                evt_err,
    input  logic                clr,
    status_code_gen_if.master   stat
`ifdef STATUS_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]    err_cnt
`endif
);
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || CNT_W < 1) begin : g_bad_param
        $error("status_code_gen: HOLD_CYCLES must be 1..255 and CNT_W >= 1");
    end

    logic    err_sticky_q;
    logic    err_sticky_d;
    logic    warn_active_c;
    status_t level_c;
    status_t status_q;
    status_t status_d;
    logic    vld_q;
    logic    vld_d;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (evt_warn),
        .clr      (clr),
        .active_c (warn_active_c)
    );

    // Sticky error, level encoding and handshake next-state.
    always_comb begin
        err_sticky_d = err_sticky_q;
        status_d     = status_q;
        vld_d        = vld_q;

        if (evt_err) begin
            err_sticky_d = 1'b1;
        end else if (clr) begin
            err_sticky_d = 1'b0;
        end

        if (err_sticky_d) begin
            level_c = ST_ERR;
        end else if (warn_active_c) begin
            level_c = ST_WARN;
        end else if (evt_busy) begin
            level_c = ST_BUSY;
        end else begin
            level_c = ST_IDLE;
        end

        // Only update when the consumer has seen the current code.
        if (!vld_q || stat.status_ack) begin
            if (level_c != status_q) begin
                status_d = level_c;
                vld_d    = 1'b1;
            end else begin
                vld_d    = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            status_q     <= ST_IDLE;
            vld_q        <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
            status_q     <= status_d;
            vld_q        <= vld_d;
        end
    end

    assign stat.status     = status_q;
    assign stat.status_vld = vld_q;

`ifdef STATUS_ERR_COUNT_EN
    logic             evt_err_q;
    logic             err_rise_c;
    logic [CNT_W-1:0] err_cnt_d;

    // Count rising edges of evt_err; clear takes the same-cycle edge into account.
    always_comb begin
        err_rise_c = evt_err & ~evt_err_q;
        err_cnt_d  = err_cnt;
        if (clr) begin
            err_cnt_d = err_rise_c ? CNT_W'(1) : '0;
        end else if (err_rise_c && (err_cnt != '1)) begin
            err_cnt_d = err_cnt + CNT_W'(1);
        end
    end

    // Edge-detect and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_err_q <= 1'b0;
            err_cnt   <= '0;
        end else begin
            evt_err_q <= evt_err;
            err_cnt   <= err_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_status_code_gen.sv
// Testbench for status_code_gen: hand-derived vector table, a randomised run
// against a reference model, and the optional error-counter sequence.
module tb_status_code_gen;
    localparam int unsigned HOLD = 4;
`ifdef STATUS_ERR_COUNT_EN
    localparam int unsigned CW = 2;
`else
    localparam int unsigned CW = 8;
`endif

    logic clk = 1'b0;
    logic rst, evt_busy, evt_warn, evt_err, clr;
    status_code_gen_if sif ();
`ifdef STATUS_ERR_COUNT_EN
    logic [CW-1:0] err_cnt;
`endif

    always #5 clk = ~clk;

    status_code_gen #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .evt_busy (evt_busy),
        .evt_warn (evt_warn),
        .evt_err  (evt_err),
        .clr      (clr),
        .stat     (sif.master)
`ifdef STATUS_ERR_COUNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    typedef struct packed {
        logic       rst, busy, warn, err, clr, ack;
        logic [1:0] st;
        logic       vld;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       vld;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam int NV = 43;
    vec_t tbl[NV];

    function automatic vec_t v(bit r, bit b, bit w, bit e, bit c, bit a, int s, bit vl);
        vec_t t;
        t.rst = r; t.busy = b; t.warn = w; t.err = e; t.clr = c; t.ack = a;
        t.st = 2'(s); t.vld = vl;
        return t;
    endfunction

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input vec_t t, input string tag);
        exp_t e;
        rst = t.rst; evt_busy = t.busy; evt_warn = t.warn; evt_err = t.err;
        clr = t.clr; sif.status_ack = t.ack;
        sb.push_back('{t.st, t.vld, tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_chk++;
        if (sif.status !== e.st || sif.status_vld !== e.vld) begin
            n_fail++;
            $display("FAIL %s: got status=%0d vld=%0d, want status=%0d vld=%0d",
                     e.tag, sif.status, sif.status_vld, e.st, e.vld);
        end
    endtask

`ifdef STATUS_ERR_COUNT_EN
    int cq[$];
    task automatic cstep(input bit r, input bit e, input bit c, input int exp_c, input string tag);
        int x;
        rst = r; evt_busy = 1'b0; evt_warn = 1'b0; evt_err = e; clr = c; sif.status_ack = 1'b1;
        cq.push_back(exp_c);
        @(posedge clk);
        #1;
        x = cq.pop_front();
        n_chk++;
        if (err_cnt !== CW'(x)) begin
            n_fail++;
            $display("FAIL %s: got err_cnt=%0d, want %0d", tag, err_cnt, x);
        end
    endtask
`endif

    // Reference model state.
    int m_err, m_warn, m_st, m_vld;

    initial begin
        //            rst busy warn err clr ack  st vld
        tbl[0]  = v(1, 1, 1, 1, 0, 0, 0, 0);  // reset beats events
        tbl[1]  = v(1, 0, 0, 1, 0, 0, 0, 0);
        tbl[2]  = v(0, 0, 0, 1, 0, 0, 3, 1);  // err after reset
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 3, 1);
        tbl[4]  = v(0, 0, 0, 0, 1, 1, 0, 1);  // clr + ack
        tbl[5]  = v(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[6]  = v(0, 1, 0, 0, 0, 0, 1, 1);  // busy handshake
        tbl[7]  = v(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[8]  = v(0, 0, 0, 0, 0, 0, 1, 1);
        tbl[9]  = v(0, 0, 0, 0, 0, 1, 0, 1);  // ack with new level pending
        tbl[10] = v(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[11] = v(0, 1, 0, 0, 0, 1, 1, 1);
        tbl[12] = v(0, 1, 0, 0, 0, 1, 1, 0);
        tbl[13] = v(0, 1, 1, 0, 0, 1, 2, 1);  // warn hold
        tbl[14] = v(0, 1, 0, 0, 0, 1, 2, 0);
        tbl[15] = v(0, 1, 0, 0, 0, 1, 2, 0);
        tbl[16] = v(0, 1, 0, 0, 0, 1, 2, 0);
        tbl[17] = v(0, 1, 0, 0, 0, 1, 1, 1);  // warn expired
        tbl[18] = v(0, 1, 0, 0, 0, 1, 1, 0);
        tbl[19] = v(0, 1, 1, 0, 0, 1, 2, 1);  // priority / sticky
        tbl[20] = v(0, 1, 0, 1, 0, 1, 3, 1);
        tbl[21] = v(0, 0, 1, 0, 0, 1, 3, 0);
        tbl[22] = v(0, 1, 0, 0, 0, 1, 3, 0);
        tbl[23] = v(0, 1, 0, 0, 1, 1, 1, 1);  // clr drops err and warn
        tbl[24] = v(0, 1, 0, 1, 0, 1, 3, 1);
        tbl[25] = v(0, 1, 0, 1, 1, 1, 3, 0);  // err beats clr
        tbl[26] = v(0, 0, 0, 0, 1, 1, 0, 1);
        tbl[27] = v(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[28] = v(0, 1, 0, 0, 0, 1, 1, 1);  // coalescing
        tbl[29] = v(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[30] = v(0, 1, 1, 0, 0, 0, 1, 1);
        tbl[31] = v(0, 0, 0, 0, 1, 0, 1, 1);
        tbl[32] = v(0, 0, 0, 0, 0, 1, 0, 1);
        tbl[33] = v(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[34] = v(0, 0, 0, 0, 0, 1, 0, 0);
        tbl[35] = v(0, 1, 0, 0, 0, 0, 1, 1);  // reset mid-handshake
        tbl[36] = v(1, 1, 0, 0, 0, 0, 0, 0);
        tbl[37] = v(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[38] = v(0, 1, 0, 0, 0, 1, 1, 0);  // ack while idle ignored
        tbl[39] = v(0, 1, 0, 0, 0, 1, 1, 0);
        tbl[40] = v(0, 0, 1, 0, 1, 1, 2, 1);  // warn beats clr
        tbl[41] = v(0, 0, 0, 0, 1, 1, 0, 1);
        tbl[42] = v(0, 0, 0, 0, 0, 1, 0, 0);

        rst = 1'b1; evt_busy = 1'b0; evt_warn = 1'b0; evt_err = 1'b0; clr = 1'b0;
        sif.status_ack = 1'b0;
        #1;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Randomised run against the reference model.
        m_err = 0; m_warn = 0; m_st = 0; m_vld = 0;
        for (int i = 0; i < 400; i++) begin
            vec_t t;
            int lvl;
            t.rst  = (i == 0) || ($urandom_range(0, 49) == 0);
            t.busy = 1'($urandom_range(0, 1));
            t.warn = ($urandom_range(0, 5) == 0);
            t.err  = ($urandom_range(0, 11) == 0);
            t.clr  = ($urandom_range(0, 7) == 0);
            t.ack  = 1'($urandom_range(0, 1));
            if (t.rst) begin
                m_err = 0; m_warn = 0; m_st = 0; m_vld = 0;
            end else begin
                m_err  = t.err ? 1 : (t.clr ? 0 : m_err);
                m_warn = t.warn ? HOLD : (t.clr ? 0 : (m_warn > 0 ? m_warn - 1 : 0));
                lvl    = m_err ? 3 : (m_warn != 0 ? 2 : (t.busy ? 1 : 0));
                if (!m_vld || t.ack) begin
                    if (lvl != m_st) begin
                        m_st = lvl; m_vld = 1;
                    end else begin
                        m_vld = 0;
                    end
                end
            end
            t.st  = 2'(m_st);
            t.vld = m_vld[0];
            step(t, $sformatf("rand[%0d]", i));
        end

`ifdef STATUS_ERR_COUNT_EN
        cstep(1, 0, 0, 0, "cnt_reset");
        for (int k = 1; k <= 5; k++) begin
            cstep(0, 1, 0, (k > 3) ? 3 : k, $sformatf("cnt_pulse%0d", k));
            cstep(0, 0, 0, (k > 3) ? 3 : k, $sformatf("cnt_gap%0d", k));
        end
        cstep(0, 0, 1, 0, "cnt_clr");
        for (int k = 0; k < 10; k++) begin
            cstep(0, 1, 0, 1, $sformatf("cnt_held%0d", k));
        end
        cstep(0, 1, 1, 0, "cnt_clr_held");
        cstep(0, 0, 0, 0, "cnt_low");
        cstep(0, 1, 1, 1, "cnt_clr_edge");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
